// File: rtl/mpsoc_boot_pkg.sv
// mpsoc_boot_pkg: shared state encoding, mode names and sizing helper for the boot sequencer.
package mpsoc_boot_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_FAULT   = 3'd4
    } boot_state_e;

    localparam string MODE_STAGGERED = "STAGGERED";
    localparam string MODE_PARALLEL  = "PARALLEL";

    // Ceiling log2 with a floor of 1 so degenerate sizes still give a usable vector.
    function automatic int log2(input int v);
        int r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mpsoc_boot_sequencer_watchdog.sv
// boot_watchdog: saturating enable/clear counter with a terminal-count flag at a programmable limit (0 = never).
module boot_watchdog #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count;
    logic [W-1:0] sat;

    assign sat = (limit == '0) ? '1 : limit;
    // Flags the edge on which the count steps onto the limit.
    assign tc  = en && (limit != '0) && (count == limit - 1'b1);

    always_ff @(posedge clk) begin
        if (clear)
            count <= '0;
        else if (en && count != sat)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mpsoc_boot_sequencer.sv
// mpsoc_boot_sequencer: staggered per-tile reset release and processor enable, with completion, halt and watchdog.
module mpsoc_boot_sequencer
    import mpsoc_boot_pkg::*;
#(
    parameter int    TILE_NUM   = 4,
    parameter int    RESET_HOLD = 20,
    parameter int    STAGGER    = 4,
    parameter int    EN_DELAY   = 2,
    parameter string MODE       = "STAGGERED",
    parameter int    TIMEOUT    = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [TILE_NUM-1:0] tile_done,
    input  logic                halt_req,
    output logic [TILE_NUM-1:0] tile_reset,
    output logic [TILE_NUM-1:0] processors_en,
    output logic                all_done,
    output logic                timeout,
    output logic                busy
);

    localparam int S  = (MODE == MODE_PARALLEL) ? 0 : STAGGER;
    localparam int CW = log2(RESET_HOLD + TILE_NUM * STAGGER + EN_DELAY + 1);
    localparam int WW = log2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_REL  = CW'(RESET_HOLD - 1);
    localparam logic [CW-1:0] C_LAST = CW'(RESET_HOLD + (TILE_NUM - 1) * S + EN_DELAY);

    boot_state_e state, state_n;
    logic [CW-1:0] c;
    logic [TILE_NUM-1:0] rst_sched, en_sched;
    logic advance, active, done, wd_en, wd_tc, fault;

    always_comb begin
        rst_sched = '0;
        en_sched  = '0;
        for (int i = 0; i < TILE_NUM; i++) begin
            rst_sched[i] = int'(c) < RESET_HOLD + i * S;
            en_sched[i]  = int'(c) >= RESET_HOLD + i * S + EN_DELAY;
        end
    end

    // Halt is only honoured once tiles may be out of reset; HOLD keeps counting regardless.
    assign active  = (state == ST_RELEASE) || (state == ST_RUN);
    assign advance = (state == ST_HOLD) || (state == ST_RELEASE && !halt_req);
    assign done    = (state == ST_RUN) && (&tile_done);
    assign wd_en   = (state == ST_RUN) && !halt_req;
    assign fault   = wd_tc && !done;

    always_comb begin
        state_n = state;
        case (state)
            ST_HOLD:    state_n = (c == C_REL) ? ST_RELEASE : ST_HOLD;
            ST_RELEASE: state_n = (!halt_req && c == C_LAST) ? ST_RUN : ST_RELEASE;
            ST_RUN:     state_n = done ? ST_DONE : (wd_tc ? ST_FAULT : ST_RUN);
            default:    state_n = state;
        endcase
    end

    boot_watchdog #(.W(WW)) u_watchdog (
        .clk   (clk),
        .clear (reset),
        .en    (wd_en),
        .limit (WW'(TIMEOUT)),
        .tc    (wd_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_HOLD;
            c             <= '0;
            tile_reset    <= '1;
            processors_en <= '0;
            all_done      <= 1'b0;
            timeout       <= 1'b0;
            busy          <= 1'b1;
        end else begin
            state    <= state_n;
            busy     <= (state_n == ST_HOLD) || (state_n == ST_RELEASE);
            all_done <= all_done | done;
            timeout  <= timeout | fault;
            if (advance) begin
                c          <= (c == C_LAST) ? c : c + 1'b1;
                tile_reset <= rst_sched;
            end
            if (active)
                processors_en <= (halt_req || fault) ? '0 : en_sched;
        end
    end

endmodule

// File: tb/tb_mpsoc_boot_sequencer.sv
// tb_mpsoc_boot_sequencer: directed and randomized checks of three boot sequencer configurations against a schedule model.
module tb_mpsoc_boot_sequencer;

    localparam int ND = 3;
    localparam int P_RH [ND] = '{20, 20, 5};
    localparam int P_S  [ND] = '{4, 0, 3};
    localparam int P_ED [ND] = '{2, 2, 1};
    localparam int P_TO [ND] = '{1000, 1000, 30};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic halt_req = 1'b0;
    logic [3:0] tile_done = '0;
    logic [3:0] rnd_td = '0;

    logic [3:0] d_rst [ND];
    logic [3:0] d_en  [ND];
    logic       d_ad  [ND];
    logic       d_to  [ND];
    logic       d_busy[ND];

    int m_c [ND];
    int m_w [ND];
    bit m_run [ND];
    bit m_done[ND];
    bit m_flt [ND];
    logic [3:0] m_rst[ND];
    logic [3:0] m_en [ND];
    logic m_ad[ND];
    logic m_to[ND];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mpsoc_boot_sequencer u_stag (
        .clk(clk), .reset(reset), .tile_done(tile_done), .halt_req(halt_req),
        .tile_reset(d_rst[0]), .processors_en(d_en[0]), .all_done(d_ad[0]), .timeout(d_to[0]), .busy(d_busy[0])
    );

    mpsoc_boot_sequencer #(.MODE("PARALLEL")) u_par (
        .clk(clk), .reset(reset), .tile_done(tile_done), .halt_req(halt_req),
        .tile_reset(d_rst[1]), .processors_en(d_en[1]), .all_done(d_ad[1]), .timeout(d_to[1]), .busy(d_busy[1])
    );

    mpsoc_boot_sequencer #(.TILE_NUM(4), .RESET_HOLD(5), .STAGGER(3), .EN_DELAY(1), .TIMEOUT(30)) u_fast (
        .clk(clk), .reset(reset), .tile_done(tile_done), .halt_req(halt_req),
        .tile_reset(d_rst[2]), .processors_en(d_en[2]), .all_done(d_ad[2]), .timeout(d_to[2]), .busy(d_busy[2])
    );

    task automatic chk(input string name, input int k, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s dut%0d got=%b want=%b at %0t", name, k, act, exp, $time);
    endtask

    // Schedule model: tile i leaves reset after RH+i*S counted edges and is enabled EN_DELAY later.
    task automatic model_step(input int k);
        int last;
        bit expire;
        last = P_RH[k] + 3 * P_S[k] + P_ED[k];
        if (reset) begin
            m_c[k] = 0; m_w[k] = 0; m_run[k] = 0; m_done[k] = 0; m_flt[k] = 0;
            m_rst[k] = 4'hf; m_en[k] = 4'h0; m_ad[k] = 0; m_to[k] = 0;
        end else if (m_done[k] || m_flt[k]) begin
        end else if (m_run[k]) begin
            expire = !halt_req && P_TO[k] != 0 && m_w[k] + 1 == P_TO[k];
            if (!halt_req) m_w[k]++;
            if (&tile_done) begin
                m_done[k] = 1; m_ad[k] = 1; m_en[k] = halt_req ? 4'h0 : 4'hf;
            end else if (expire) begin
                m_flt[k] = 1; m_to[k] = 1; m_en[k] = 4'h0;
            end else m_en[k] = halt_req ? 4'h0 : 4'hf;
        end else if (halt_req && m_c[k] >= P_RH[k]) begin
            m_en[k] = 4'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_rst[k][i] = m_c[k] < P_RH[k] + i * P_S[k];
                m_en[k][i]  = m_c[k] >= P_RH[k] + i * P_S[k] + P_ED[k];
            end
            if (m_c[k] == last) m_run[k] = 1;
            else m_c[k]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < ND; k++) model_step(k);
        #1;
        for (int k = 0; k < ND; k++) begin
            chk("tile_reset", k, d_rst[k], m_rst[k]);
            chk("processors_en", k, d_en[k], m_en[k]);
            chk("all_done", k, d_ad[k], m_ad[k]);
            chk("timeout", k, d_to[k], m_to[k]);
            chk("busy", k, d_busy[k], !(m_run[k] || m_done[k] || m_flt[k]));
        end
    endtask

    task automatic drive(input int kind, input int n);
        reset = 1'b0; halt_req = 1'b0; tile_done = '0;
        case (kind)
            1: begin
                tile_done = (n < 100) ? 4'h0 : (n < 150 ? 4'hf : 4'($urandom));
                halt_req  = (n >= 150) && $urandom_range(0, 1) == 1;
            end
            2: tile_done = 4'b0111;
            3: halt_req = (n >= 25 && n <= 29);
            4: reset = (n == 27);
            5: begin
                reset = $urandom_range(0, 399) == 0;
                halt_req = $urandom_range(0, 9) < 2;
                if ($urandom_range(0, 29) == 0) rnd_td[$urandom_range(0, 3)] = 1'b1;
                if ($urandom_range(0, 499) == 0 || reset) rnd_td = '0;
                tile_done = rnd_td;
            end
            default: ;
        endcase
    endtask

    task automatic literals(input int kind, input int n);
        if (kind == 0) begin
            if (n == 19) chk("stag_rst19", 0, d_rst[0], 4'b1111);
            if (n == 20) chk("stag_rst20", 0, d_rst[0], 4'b1110);
            if (n == 24) chk("stag_rst24", 0, d_rst[0], 4'b1100);
            if (n == 28) chk("stag_rst28", 0, d_rst[0], 4'b1000);
            if (n == 32) chk("stag_rst32", 0, d_rst[0], 4'b0000);
            if (n == 22) chk("stag_en22", 0, d_en[0], 4'b0001);
            if (n == 26) chk("stag_en26", 0, d_en[0], 4'b0011);
            if (n == 30) chk("stag_en30", 0, d_en[0], 4'b0111);
            if (n == 34) chk("stag_en34", 0, d_en[0], 4'b1111);
            if (n == 33) chk("stag_busy33", 0, d_busy[0], 1'b1);
            if (n == 34) chk("stag_busy34", 0, d_busy[0], 1'b0);
            if (n == 19) chk("par_rst19", 1, d_rst[1], 4'b1111);
            if (n == 20) chk("par_rst20", 1, d_rst[1], 4'b0000);
            if (n == 21) chk("par_en21", 1, d_en[1], 4'b0000);
            if (n == 22) chk("par_en22", 1, d_en[1], 4'b1111);
            if (n == 21) chk("par_busy21", 1, d_busy[1], 1'b1);
            if (n == 22) chk("par_busy22", 1, d_busy[1], 1'b0);
        end
        if (kind == 1) begin
            if (n == 99) chk("done99", 0, d_ad[0], 1'b0);
            if (n == 100) chk("done100", 0, d_ad[0], 1'b1);
            if (n == 1999) chk("done_sticky", 0, d_ad[0], 1'b1);
            if (n == 1999) chk("no_timeout", 0, d_to[0], 1'b0);
        end
        if (kind == 2) begin
            if (n == 1033) chk("to1033", 0, d_to[0], 1'b0);
            if (n == 1033) chk("en1033", 0, d_en[0], 4'b1111);
            if (n == 1034) chk("to1034", 0, d_to[0], 1'b1);
            if (n == 1034) chk("en1034", 0, d_en[0], 4'b0000);
            if (n == 1034) chk("rst1034", 0, d_rst[0], 4'b0000);
            if (n == 1021) chk("par_to1021", 1, d_to[1], 1'b0);
            if (n == 1022) chk("par_to1022", 1, d_to[1], 1'b1);
        end
        if (kind == 3) begin
            if (n == 24 || n == 30) chk("halt_en0_on", 0, d_en[0][0], 1'b1);
            if (n >= 25 && n <= 29) chk("halt_en0_off", 0, d_en[0][0], 1'b0);
            if (n == 32) chk("halt_rst2_32", 0, d_rst[0][2], 1'b1);
            if (n == 33) chk("halt_rst2_33", 0, d_rst[0][2], 1'b0);
            if (n == 36) chk("halt_rst3_36", 0, d_rst[0][3], 1'b1);
            if (n == 37) chk("halt_rst3_37", 0, d_rst[0][3], 1'b0);
            if (n == 38) chk("halt_en38", 0, d_en[0], 4'b0111);
            if (n == 39) chk("halt_en39", 0, d_en[0], 4'b1111);
            if (n == 39) chk("halt_busy39", 0, d_busy[0], 1'b0);
        end
        if (kind == 4) begin
            if (n == 26) chk("rr_en26", 0, d_en[0], 4'b0011);
            if (n == 27) chk("rr_rst27", 0, d_rst[0], 4'b1111);
            if (n == 27) chk("rr_en27", 0, d_en[0], 4'b0000);
            if (n == 47) chk("rr_rst47", 0, d_rst[0], 4'b1111);
            if (n == 48) chk("rr_rst48", 0, d_rst[0], 4'b1110);
            if (n == 62) chk("rr_en62", 0, d_en[0], 4'b1111);
            if (n == 62) chk("rr_busy62", 0, d_busy[0], 1'b0);
        end
    endtask

    task automatic run_scn(input int kind, input int n_edges);
        reset = 1'b1; halt_req = 1'b0; tile_done = '0; rnd_td = '0;
        step();
        step();
        chk("reset_rst", 0, d_rst[0], 4'b1111);
        chk("reset_en", 0, d_en[0], 4'b0000);
        chk("reset_busy", 0, d_busy[0], 1'b1);
        for (int n = 0; n < n_edges; n++) begin
            drive(kind, n);
            step();
            literals(kind, n);
        end
    endtask

    initial begin
        run_scn(0, 60);
        run_scn(1, 2000);
        run_scn(2, 1040);
        run_scn(3, 60);
        run_scn(4, 70);
        run_scn(5, 3000);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mpsoc_boot_sequencer.md
# mpsoc_boot_sequencer

Parametrised boot and run controller for an N-tile mor1k MPSoC. It replaces the fixed "hold reset, then enable every processor at once" start-up with a per-tile staggered reset release and processor enable. It also adds completion detection, a halt mask and a run watchdog. It sits between the system clock/reset source and the tile `reset` / `processors_en` inputs, in simulation benches and on FPGA tops.

## Interface
- `TILE_NUM`, 4: number of tiles controlled; ≥1.
- `RESET_HOLD`, 20: cycles all tiles stay in reset after `reset` falls; ≥1.
- `STAGGER`, 4: cycles between successive tile reset releases in STAGGERED mode.
- `EN_DELAY`, 2: cycles from a tile's reset release to its processor enable.
- `MODE`, "STAGGERED": "STAGGERED" or "PARALLEL". PARALLEL behaves as STAGGER=0.
- `TIMEOUT`, 1000: RUN-cycle watchdog limit; 0 disables the watchdog.
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `tile_done` in TILE_NUM: per-tile "program finished" level.
- `halt_req` in 1: level. Masks processor enables and freezes all counters.
- `tile_reset` out TILE_NUM: per-tile reset, active-high. Registered.
- `processors_en` out TILE_NUM: per-tile processor enable. Registered.
- `all_done` out 1: sticky; all tiles reported done.
- `timeout` out 1: sticky; watchdog expired.
- `busy` out 1: high in HOLD and RELEASE.

## Operation
- States: HOLD → RELEASE → RUN → DONE, or RUN → FAULT.
- Reset values: state HOLD, counters 0, `tile_reset`=all 1, `processors_en`=0, `all_done`=0, `timeout`=0, `busy`=1.
- Sequence counter `c` counts edges with `reset`=0 and `halt_req`=0. Edge 0 is the first edge with `reset` low.
- `tile_reset[i]` clears at c = RESET_HOLD + i·S.
- `processors_en[i]` sets at c = RESET_HOLD + i·S + EN_DELAY.
- S is STAGGER, or 0 when MODE is PARALLEL.
- HOLD→RELEASE when c = RESET_HOLD−1.
- RELEASE→RUN on the edge that sets the last enable.
- RUN:
  - Watchdog counts edges with `halt_req`=0.
  - `&tile_done` sampled 1 → DONE. On that edge `all_done` is set and stays set.
  - Watchdog count reaches TIMEOUT (TIMEOUT≠0) → FAULT. On that edge `timeout`=1 and `processors_en` is forced to 0; `tile_reset` stays 0.
- Done and timeout on the same edge: DONE wins and `timeout` stays 0.
- DONE: outputs hold; `tile_done` is ignored afterwards.
- FAULT: outputs hold until `reset`.
- `halt_req` sampled 1 in RELEASE or RUN:
  - `processors_en` <= 0 on that edge.
  - Sequence counter and watchdog hold.
  - `tile_reset` holds.
- `halt_req` sampled 0: `processors_en` <= its scheduled value.
- `halt_req` is ignored in HOLD, DONE and FAULT.
- Sequence counter width: log2(RESET_HOLD + TILE_NUM·STAGGER + EN_DELAY + 1).
- Watchdog width: log2(TIMEOUT+1). The watchdog saturates; it never wraps.

## Timing
- All outputs are registered.
- Latency from an input sampled at an edge to the output change is that same edge; there are no combinational paths.
- `reset` asserted mid-sequence or mid-run: the next edge restores all reset values, clears sticky flags, and restarts from HOLD.
- `tile_done` bits may rise in any order and must be held high. `all_done` requires all bits high on one sampled edge.
- TILE_NUM=1: RELEASE lasts EN_DELAY edges, and STAGGER has no effect.

## Structure
- Package `mpsoc_boot_pkg` holds:
  - state enum (HOLD, RELEASE, RUN, DONE, FAULT);
  - `log2` function;
  - MODE string constants.
- Sub-module `boot_watchdog` is a saturating counter with enable and clear, and a terminal-count flag at a programmable limit; 0 means never.
- Top level contains the FSM, sequence counter and per-tile compare logic.

## Test plan
All scenarios use defaults unless noted: TILE_NUM=4, RESET_HOLD=20, STAGGER=4, EN_DELAY=2, TIMEOUT=1000.
- Staggered boot:
  - `tile_reset` = 1110 at edge 20, 1100 at 24, 1000 at 28, 0000 at 32.
  - `processors_en` bits set at edges 22, 26, 30, 34.
  - `busy` falls at 34.
- MODE="PARALLEL": `tile_reset`=0000 at edge 20; `processors_en`=1111 at 22; RUN at 22.
- `tile_done`=1111 applied from edge 100 → `all_done`=1 at edge 100 and sticky; `timeout` stays 0 to edge 2000.
- `tile_done` held 0111 → `timeout`=1 and `processors_en`=0000 at edge 1034; `tile_reset` stays 0000.
- `halt_req` high for edges 25–29:
  - `processors_en[0]`=0 on 25–29, back to 1 at 30.
  - `tile_reset[2]` clears at 33, `tile_reset[3]` at 37.
  - Last enable sets at 39.
- `reset` reasserted at edge 27 for one cycle → edge 27: `tile_reset`=1111, `processors_en`=0000; the sequence repeats offset by 28 edges.
